pad_input_conditioner: RTL and testbench

PAD_INPUT_CONDITIONER -- requirements
Module: pad_input_conditioner

---
 rtl/pad_input_conditioner_pkg.sv | 33 +++
 rtl/pad_input_conditioner_if.sv | 29 ++
 rtl/prim_flop_2sync.sv | 29 ++
 rtl/pad_input_conditioner.sv | 76 +++++++
 tb/tb_pad_input_conditioner.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pad_input_conditioner_pkg.sv
// Shared types for the pad input conditioner: the per-cycle glitch filter decision
// and the function that makes it.
package pad_input_conditioner_pkg;

  localparam int unsigned DefaultCntWidth = 16;

  typedef enum logic [1:0] {
    FiltHold   = 2'd0,
    FiltCount  = 2'd1,
    FiltCommit = 2'd2,
    FiltReject = 2'd3
  } filt_action_e;

  // Bypass commits any difference at once. With the filter on, a pending change that
  // disappears before its threshold is reached is reported as rejected.
  function automatic filt_action_e filt_decide(input logic enable,
                                               input logic differ,
                                               input logic cnt_zero,
                                               input logic cnt_ge_thresh);
    filt_action_e act;
    if (!enable) begin
      act = differ ? FiltCommit : FiltHold;
    end else if (!differ) begin
      act = cnt_zero ? FiltHold : FiltReject;
    end else if (cnt_ge_thresh) begin
      act = FiltCommit;
    end else begin
      act = FiltCount;
    end
    return act;
  endfunction

endpackage

// File: rtl/pad_input_conditioner_if.sv
// Signal bundle between a pad-side driver and the input conditioner.
// The master drives the raw pad level and filter controls; the slave returns the conditioned level and events.
interface pad_input_conditioner_if #(
  parameter int unsigned CntWidth = 16
) (
  input logic clk_i
);

  logic                in_i;
  logic                enable_i;
  logic [CntWidth-1:0] thresh_i;
  logic                filtered_o;
  logic                rise_o;
  logic                fall_o;
  logic                glitch_o;

  modport master (
    input  clk_i,
    output in_i, enable_i, thresh_i,
    input  filtered_o, rise_o, fall_o, glitch_o
  );

  modport slave (
    input  clk_i,
    input  in_i, enable_i, thresh_i,
    output filtered_o, rise_o, fall_o, glitch_o
  );

endinterface

// File: rtl/prim_flop_2sync.sv
// Two-flop synchronizer that brings an asynchronous level into the clk_i domain.
module prim_flop_2sync #(
  parameter int unsigned     Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so that both stages sample
  // their inputs from before the clock edge. A blocking assignment would merge the two flops into one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetValue;
      sync_q <= ResetValue;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// Pad input conditioner: synchronizes a raw pad level, applies a consecutive-cycle glitch filter
// and reports committed edges and rejected glitches.
module pad_input_conditioner
  import pad_input_conditioner_pkg::*;
#(
  parameter int unsigned CntWidth   = DefaultCntWidth,
  parameter logic        ResetValue = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_i,
  input  logic                enable_i,
  input  logic [CntWidth-1:0] thresh_i,
  output logic                filtered_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                glitch_o
);

  logic                sync_q;
  logic                stable_q, stable_d;
  logic                prev_q;
  logic                glitch_q, glitch_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  filt_action_e        action;

  prim_flop_2sync #(
    .Width      (1),
    .ResetValue (ResetValue)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (in_i),
    .q_o    (sync_q)
  );

  // The >= compare commits immediately if thresh_i is lowered below a running count.
  // The counter only increments while below thresh_i, so it cannot wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    stable_d = stable_q;
    cnt_d    = '0;
    glitch_d = 1'b0;
    action   = filt_decide(enable_i, sync_q != stable_q, cnt_q == '0, cnt_q >= thresh_i);
    unique case (action)
      FiltHold:   cnt_d = '0;
      FiltCount:  cnt_d = cnt_q + CntWidth'(1);
      FiltCommit: stable_d = sync_q;
      FiltReject: glitch_d = 1'b1;
      default:    cnt_d = '0;
    endcase
  end

  // NOTE: every flop, including the counter, has an asynchronous reset. A reset during a count
  // therefore drops the pending change and cannot leave a stale count behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= ResetValue;
      prev_q   <= ResetValue;
      cnt_q    <= '0;
      glitch_q <= 1'b0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
    end
  end

  // prev_q resets alongside stable_q, so reset release never creates an edge pulse.
  assign filtered_o = stable_q;
  assign rise_o     = stable_q & ~prev_q;
  assign fall_o     = ~stable_q & prev_q;
  assign glitch_o   = glitch_q;

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Self-checking bench for pad_input_conditioner. Expected edge/glitch events are queued at their
// predicted cycle when stimulus is applied, and a monitor compares them with the DUT pulses.
module tb_pad_input_conditioner;

  typedef enum int {EV_RISE = 0, EV_FALL = 1, EV_GLITCH = 2} ev_e;
  typedef struct {
    int  dut;
    ev_e kind;
    int  cyc;
  } ev_t;

  logic clk;
  logic rst0_n;
  logic rst1_n;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  sb[$];

  pad_input_conditioner_if #(.CntWidth(16)) if0 (.clk_i(clk));
  pad_input_conditioner_if #(.CntWidth(4))  if1 (.clk_i(clk));

  pad_input_conditioner #(.CntWidth(16), .ResetValue(1'b0)) dut0 (
    .clk_i      (clk),
    .rst_ni     (rst0_n),
    .in_i       (if0.in_i),
    .enable_i   (if0.enable_i),
    .thresh_i   (if0.thresh_i),
    .filtered_o (if0.filtered_o),
    .rise_o     (if0.rise_o),
    .fall_o     (if0.fall_o),
    .glitch_o   (if0.glitch_o)
  );

  pad_input_conditioner #(.CntWidth(4), .ResetValue(1'b1)) dut1 (
    .clk_i      (clk),
    .rst_ni     (rst1_n),
    .in_i       (if1.in_i),
    .enable_i   (if1.enable_i),
    .thresh_i   (if1.thresh_i),
    .filtered_o (if1.filtered_o),
    .rise_o     (if1.rise_o),
    .fall_o     (if1.fall_o),
    .glitch_o   (if1.glitch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every pulse seen must be the next expected event, at the predicted cycle.
  always @(negedge clk) begin
    logic [2:0] obs [2];
    obs[0] = {if0.glitch_o, if0.fall_o, if0.rise_o};
    obs[1] = {if1.glitch_o, if1.fall_o, if1.rise_o};
    for (int d = 0; d < 2; d++) begin
      if (obs[d][0] === 1'b1 || obs[d][1] === 1'b1) begin
        checks++;
        if (obs[d][1:0] === 2'b11) begin
          errors++;
          $display("FAIL rise_fall_excl dut%0d cycle %0d: rise and fall both high", d, cyc);
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (obs[d][k] === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event dut%0d: got %s at cycle %0d, expected none",
                     d, ev_e'(k), cyc);
          end else begin
            ev_t e;
            e = sb.pop_front();
            if (e.dut !== d || e.kind !== ev_e'(k) || e.cyc !== cyc) begin
              errors++;
              $display("FAIL event_order: got dut%0d %s at cycle %0d, expected dut%0d %s at cycle %0d",
                       d, ev_e'(k), cyc, e.dut, e.kind, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int d, input ev_e k, input int at);
    ev_t e;
    e.dut  = d;
    e.kind = k;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    step(3);
    checks++;
    if (if0.filtered_o !== 1'b0) begin
      errors++; $display("FAIL reset_filtered0: got %b, expected 0", if0.filtered_o);
    end
    checks++;
    if ({if0.rise_o, if0.fall_o, if0.glitch_o} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses0: got %b, expected 000", {if0.rise_o, if0.fall_o, if0.glitch_o});
    end
    checks++;
    if (if1.filtered_o !== 1'b1) begin
      errors++; $display("FAIL reset_filtered1: got %b, expected 1", if1.filtered_o);
    end
    checks++;
    if ({if1.rise_o, if1.fall_o, if1.glitch_o} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses1: got %b, expected 000", {if1.rise_o, if1.fall_o, if1.glitch_o});
    end
    rst0_n = 1'b1;
    step(5);
    checks++;
    if (if0.filtered_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_filtered0: got %b, expected 0", if0.filtered_o);
    end
  endtask

  task automatic test_filter_rise();
    int c;
    c = cyc;
    if0.in_i = 1'b1;
    push_ev(0, EV_RISE, c + 6);
    step(5);
    checks++;
    if (if0.filtered_o !== 1'b0) begin
      errors++; $display("FAIL rise_early: got %b at +5, expected 0", if0.filtered_o);
    end
    step(1);
    checks++;
    if (if0.filtered_o !== 1'b1 || if0.rise_o !== 1'b1) begin
      errors++; $display("FAIL rise_at_6: got filtered=%b rise=%b, expected 1 1", if0.filtered_o, if0.rise_o);
    end
    step(3);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rise_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_glitch();
    int c;
    c = cyc;
    if0.in_i = 1'b0;
    push_ev(0, EV_FALL, c + 6);
    step(8);
    c = cyc;
    if0.in_i = 1'b1;
    push_ev(0, EV_GLITCH, c + 5);
    step(2);
    if0.in_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      checks++;
      if (if0.filtered_o !== 1'b0) begin
        errors++; $display("FAIL glitch_level: got %b at +%0d, expected 0", if0.filtered_o, i + 3);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL glitch_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_bypass();
    int c;
    if0.enable_i = 1'b0;
    c = cyc;
    if0.in_i = 1'b1;
    push_ev(0, EV_RISE, c + 3);
    step(5);
    c = cyc;
    if0.in_i = 1'b0;
    push_ev(0, EV_FALL, c + 3);
    step(2);
    checks++;
    if (if0.filtered_o !== 1'b1) begin
      errors++; $display("FAIL bypass_early: got %b at +2, expected 1", if0.filtered_o);
    end
    step(1);
    checks++;
    if (if0.filtered_o !== 1'b0 || if0.fall_o !== 1'b1) begin
      errors++; $display("FAIL bypass_fall: got filtered=%b fall=%b, expected 0 1", if0.filtered_o, if0.fall_o);
    end
    step(3);
    if0.enable_i = 1'b1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL bypass_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_enable_drop();
    int c;
    c = cyc;
    if0.in_i = 1'b1;
    push_ev(0, EV_RISE, c + 4);
    step(3);
    if0.enable_i = 1'b0;
    step(1);
    checks++;
    if (if0.filtered_o !== 1'b1) begin
      errors++; $display("FAIL enable_drop_commit: got %b, expected 1", if0.filtered_o);
    end
    step(3);
    if0.enable_i = 1'b1;
    c = cyc;
    if0.in_i = 1'b0;
    push_ev(0, EV_FALL, c + 6);
    step(8);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL enable_drop_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_thresh_lower();
    int c;
    if0.thresh_i = 16'd10;
    c = cyc;
    if0.in_i = 1'b1;
    step(7);
    checks++;
    if (dut0.cnt_q !== 16'd5) begin
      errors++; $display("FAIL thresh_lower_cnt: got %0d, expected 5", dut0.cnt_q);
    end
    if0.thresh_i = 16'd2;
    push_ev(0, EV_RISE, c + 8);
    step(1);
    checks++;
    if (if0.filtered_o !== 1'b1 || dut0.cnt_q !== 16'd0) begin
      errors++; $display("FAIL thresh_lower_commit: got filtered=%b cnt=%0d, expected 1 0", if0.filtered_o, dut0.cnt_q);
    end
    c = cyc;
    if0.in_i = 1'b0;
    push_ev(0, EV_FALL, c + 5);
    step(4);
    checks++;
    if (if0.filtered_o !== 1'b1) begin
      errors++; $display("FAIL thresh2_early: got %b, expected 1", if0.filtered_o);
    end
    step(1);
    checks++;
    if (if0.filtered_o !== 1'b0) begin
      errors++; $display("FAIL thresh2_fall: got %b, expected 0", if0.filtered_o);
    end
    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL thresh_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    int c;
    if0.thresh_i = 16'd0;
    for (int i = 0; i < 6; i++) begin
      c = cyc;
      if0.in_i = ~if0.in_i;
      push_ev(0, if0.in_i ? EV_RISE : EV_FALL, c + 3);
      step(1);
    end
    step(6);
    checks++;
    if (if0.filtered_o !== 1'b0) begin
      errors++; $display("FAIL b2b_level: got %b, expected 0", if0.filtered_o);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL b2b_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_discard();
    if0.thresh_i = 16'd3;
    if0.in_i = 1'b1;
    step(4);
    rst0_n = 1'b0;
    if0.in_i = 1'b0;
    #1;
    checks++;
    if (if0.filtered_o !== 1'b0 || dut0.cnt_q !== 16'd0) begin
      errors++; $display("FAIL discard_in_reset: got filtered=%b cnt=%0d, expected 0 0", if0.filtered_o, dut0.cnt_q);
    end
    step(1);
    rst0_n = 1'b1;
    step(10);
    checks++;
    if (if0.filtered_o !== 1'b0) begin
      errors++; $display("FAIL discard_level: got %b, expected 0", if0.filtered_o);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL discard_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_value_one();
    int c;
    checks++;
    if (if1.filtered_o !== 1'b1) begin
      errors++; $display("FAIL rv1_in_reset: got %b, expected 1", if1.filtered_o);
    end
    c = cyc;
    rst1_n = 1'b1;
    push_ev(1, EV_FALL, c + 3);
    step(2);
    checks++;
    if (if1.filtered_o !== 1'b1) begin
      errors++; $display("FAIL rv1_early: got %b at +2, expected 1", if1.filtered_o);
    end
    step(1);
    checks++;
    if (if1.filtered_o !== 1'b0 || if1.fall_o !== 1'b1) begin
      errors++; $display("FAIL rv1_fall: got filtered=%b fall=%b, expected 0 1", if1.filtered_o, if1.fall_o);
    end
    step(3);
    if1.thresh_i = 4'd5;
    if1.in_i = 1'b1;
    step(4);
    rst1_n = 1'b0;
    #1;
    checks++;
    if (if1.filtered_o !== 1'b1 || {if1.rise_o, if1.fall_o} !== 2'b00) begin
      errors++; $display("FAIL rv1_mid_reset: got filtered=%b rise/fall=%b%b, expected 1 00",
                         if1.filtered_o, if1.rise_o, if1.fall_o);
    end
    step(2);
    rst1_n = 1'b1;
    step(10);
    checks++;
    if (if1.filtered_o !== 1'b1) begin
      errors++; $display("FAIL rv1_after_reset: got %b, expected 1", if1.filtered_o);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rv1_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_max_thresh();
    int c;
    if1.thresh_i = 4'hF;
    c = cyc;
    if1.in_i = 1'b0;
    push_ev(1, EV_FALL, c + 18);
    step(17);
    checks++;
    if (if1.filtered_o !== 1'b1 || dut1.cnt_q !== 4'hF) begin
      errors++; $display("FAIL max_early: got filtered=%b cnt=%0d, expected 1 15", if1.filtered_o, dut1.cnt_q);
    end
    step(1);
    checks++;
    if (if1.filtered_o !== 1'b0 || dut1.cnt_q !== 4'h0) begin
      errors++; $display("FAIL max_commit: got filtered=%b cnt=%0d, expected 0 0", if1.filtered_o, dut1.cnt_q);
    end
    c = cyc;
    if1.in_i = 1'b1;
    push_ev(1, EV_RISE, c + 18);
    step(18);
    checks++;
    if (if1.filtered_o !== 1'b1) begin
      errors++; $display("FAIL max_rise: got %b, expected 1", if1.filtered_o);
    end
    step(2);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL max_drain: got %0d pending events, expected 0", sb.size()); sb.delete();
    end
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    if0.in_i = 1'b0; if0.enable_i = 1'b1; if0.thresh_i = 16'd3;
    if1.in_i = 1'b0; if1.enable_i = 1'b1; if1.thresh_i = 4'd0;
    test_reset();
    test_filter_rise();
    test_glitch();
    test_bypass();
    test_enable_drop();
    test_thresh_lower();
    test_back_to_back();
    test_reset_discard();
    test_reset_value_one();
    test_max_thresh();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
